// File: rtl/wr_ddr_burst_fifo.sv
// wr_ddr_burst_fifo: DDR write-side FIFO with FWFT option, burst framing, flush and sticky error flags
module wr_ddr_burst_fifo #(
  parameter int c_DATA_WIDTH       = 32,
  parameter int c_DEPTH_WIDTH      = 9,
  parameter int c_FWFT             = 1,
  parameter int c_BURST_LEN        = 16,
  parameter int c_ALMOST_FULL_NUM  = 500,
  parameter int c_ALMOST_EMPTY_NUM = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [c_DATA_WIDTH-1:0]  wr_data,
  input  logic                     wr_en,
  output logic                     wr_full,
  output logic                     almost_full,
  input  logic                     rd_en,
  output logic [c_DATA_WIDTH-1:0]  rd_data,
  output logic                     rd_valid,
  output logic                     rd_last,
  output logic                     rd_empty,
  output logic                     almost_empty,
  output logic                     burst_rdy,
  output logic [c_DEPTH_WIDTH:0]   water_level,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     err_clr
);
  localparam int AW = c_DEPTH_WIDTH;
  localparam int LW = c_DEPTH_WIDTH + 1;
  localparam int CW = (c_BURST_LEN > 1) ? $clog2(c_BURST_LEN) : 1;
  localparam logic [AW:0] DEPTH = LW'(1 << AW);
  localparam logic [AW:0] AF = LW'(c_ALMOST_FULL_NUM);
  localparam logic [AW:0] AE = LW'(c_ALMOST_EMPTY_NUM);
  localparam logic [AW:0] BL = LW'(c_BURST_LEN);
  localparam logic [CW-1:0] LAST = CW'(c_BURST_LEN - 1);
  localparam bit FWFT = c_FWFT != 0;
  logic [c_DATA_WIDTH-1:0] mem [0:(1<<AW)-1];
  logic [c_DATA_WIDTH-1:0] ram_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level, lvl_n;
  logic [CW-1:0] cnt, cnt_n;
  logic stg, stg_n, wr_acc, rd_acc, ovf_set, unf_set, move, fetch, adv, valid_n, last_n;
  assign water_level = level;
  // FWFT keeps two staged words (ram_q in stg, rd_data in rd_valid); level counts them too
  always_comb begin
    wr_acc  = wr_en & ~wr_full & ~flush;
    rd_acc  = rd_en & (FWFT ? rd_valid : ~rd_empty) & ~flush;
    ovf_set = wr_en & wr_full & ~flush;
    unf_set = rd_en & (FWFT ? ~rd_valid : rd_empty) & ~flush;
    lvl_n   = flush ? '0 : level + LW'(wr_acc) - LW'(rd_acc);
    move    = FWFT & stg & (~rd_valid | rd_acc);
    fetch   = FWFT & ~flush & (level != LW'(stg) + LW'(rd_valid)) & (~stg | move);
    adv     = FWFT ? fetch : rd_acc;
    stg_n   = ~flush & (fetch | (stg & ~move));
    cnt_n   = flush ? '0 : rd_acc ? (cnt == LAST ? '0 : cnt + CW'(1)) : cnt;
    valid_n = ~flush & (FWFT ? move | (rd_valid & ~rd_acc) : rd_acc);
    last_n  = FWFT ? valid_n & (cnt_n == LAST) : rd_acc & (cnt == LAST);
  end
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
    if (fetch) ram_q <= mem[rd_ptr];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      stg          <= 1'b0;
      rd_valid     <= 1'b0;
      rd_last      <= 1'b0;
      rd_data      <= '0;
      wr_full      <= 1'b0;
      almost_full  <= 1'b0;
      rd_empty     <= 1'b1;
      almost_empty <= 1'b1;
      burst_rdy    <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      level        <= lvl_n;
      wr_ptr       <= flush ? '0 : wr_ptr + AW'(wr_acc);
      rd_ptr       <= flush ? '0 : rd_ptr + AW'(adv);
      cnt          <= cnt_n;
      stg          <= stg_n;
      rd_valid     <= valid_n;
      rd_last      <= last_n;
      if (flush) rd_data <= '0;
      else if (FWFT ? move : rd_acc) rd_data <= FWFT ? ram_q : mem[rd_ptr];
      wr_full      <= lvl_n == DEPTH;
      almost_full  <= lvl_n >= AF;
      rd_empty     <= lvl_n == '0;
      almost_empty <= lvl_n <= AE;
      burst_rdy    <= lvl_n >= BL;
      overflow     <= ovf_set | (overflow & ~err_clr);
      underflow    <= unf_set | (underflow & ~err_clr);
    end
  end
endmodule
